lms_tap_sequencer: RTL
======================

Name: lms_tap_sequencer

Overview:
- Control FSM that sequences one LMS iteration per input sample for the 16-tap adaptive filter datapath.
- Per sample, in order:
  - shifts the delay line;
  - steps the tap index through the MAC accumulation;
  - strobes error computation;
  - steps the tap index through the weight-update/write-back pass;
  - presents the result over a valid/ready handshake.
- Sits between the sample source (ADC/buffer front end) and the filter MAC, error and weight-RAM datapath.
- Generates no arithmetic itself. Only strobes, tap index and handshakes.

Parameters:
- NTAPS, 16, number of filter taps (≥2).
- IDX_W, 4, tap index width, equal to clog2(NTAPS).
- CNT_W, 16, width of the processed-sample counter.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  run enable; deassertion aborts any iteration.
- freeze  in  1  skip weight-update pass (filter only); sampled in ERR state.
- in_valid  in  1  new sample available.
- in_ready  out  1  controller accepts sample.
- out_valid  out  1  filter output d/e valid on datapath.
- out_ready  in  1  consumer takes output.
- shift_en  out  1  one-cycle pulse: shift delay line / load sample.
- mac_clr  out  1  one-cycle pulse: clear accumulator.
- mac_en  out  1  accumulate reff[tap_idx]*w[tap_idx].
- err_en  out  1  one-cycle pulse: latch e = desired − d.
- upd_en  out  1  weight update for tap_idx active.
- w_we  out  1  weight RAM write enable, equal to upd_en.
- tap_idx  out  IDX_W  current tap during MAC/UPD, else 0.
- busy  out  1  high in every state except IDLE.
- sample_cnt  out  CNT_W  completed iterations, wraps modulo 2^CNT_W.

Behaviour:
- Reset values:
  - state IDLE; tap_idx 0; sample_cnt 0.
  - All strobes 0; out_valid 0; busy 0; in_ready 0.
- States: IDLE, SHIFT, MAC, ERR, UPD, OUT.
- IDLE:
  - in_ready = enable, combinational from state and enable.
  - in_valid & in_ready at edge E0 → SHIFT.
- SHIFT (1 cycle):
  - shift_en = 1, mac_clr = 1.
  - Next state MAC with tap_idx = 0.
- MAC (NTAPS cycles):
  - mac_en = 1.
  - tap_idx increments each cycle.
  - At tap_idx = NTAPS−1 → ERR, tap_idx ← 0.
- ERR (1 cycle):
  - err_en = 1.
  - freeze = 0 → UPD with tap_idx = 0.
  - freeze = 1 → OUT.
- UPD (NTAPS cycles):
  - upd_en = w_we = 1.
  - tap_idx increments each cycle.
  - At tap_idx = NTAPS−1 → OUT, tap_idx ← 0.
- OUT:
  - out_valid = 1, held stable until out_ready.
  - out_valid & out_ready → IDLE and sample_cnt + 1.
  - sample_cnt wraps from all-ones to 0.
- Latency, with enable held throughout:
  - out_valid rises 2·NTAPS+2 cycles after E0 (34 at default).
  - With freeze: NTAPS+2 cycles (18 at default).
- Throughput: back-to-back samples have ≥1 IDLE cycle between out handshake and next acceptance. in_ready is never high outside IDLE.
- enable low in any non-IDLE state:
  - Next edge → IDLE, tap_idx ← 0, mac_clr pulses on that edge's following cycle.
  - No err_en/w_we issued after the abort edge.
  - sample_cnt unchanged.
  - out_valid drops (abort in OUT discards output).
- freeze changes outside ERR have no effect on the current iteration.
- in_valid asserted while busy: ignored; no ready, no accept.
- Asynchronous reset mid-iteration: immediate return to reset values. No further w_we.
- Invariants:
  - Exactly one of {shift_en, mac_en, err_en, upd_en, out_valid} is high per non-IDLE cycle; mac_clr is the only companion strobe, alongside shift_en.
  - tap_idx never exceeds NTAPS−1.

Decomposition:
- Package lms_seq_pkg holds:
  - state enum (IDLE, SHIFT, MAC, ERR, UPD, OUT);
  - default NTAPS constant;
  - IDX_W derivation function.
- One natural sub-module, lms_tap_counter:
  - IDX_W counter with clear, enable and terminal-count flag at NTAPS−1.
  - Reused for the MAC and UPD passes.

Test Plan:
- Reset, then enable = 1, in_valid pulse:
  - shift_en and mac_clr high 1 cycle.
  - mac_en 16 cycles with tap_idx 0..15.
  - err_en 1 cycle; w_we 16 cycles with tap_idx 0..15.
  - out_valid high at cycle 34 after accept; out_ready = 1 → sample_cnt = 1.
- freeze = 1 during ERR: no upd_en/w_we; out_valid at cycle 18; sample_cnt increments.
- out_ready held low 5 cycles in OUT: out_valid stays high, in_ready stays 0, in_valid pulses ignored. Release → IDLE, in_ready = 1 next cycle.
- enable dropped at MAC tap_idx = 7: next cycle state IDLE, busy 0, tap_idx 0, mac_clr pulse, no err_en/w_we, sample_cnt unchanged.
- rstn asserted during UPD at tap_idx = 9: all outputs immediately reset values, no further w_we. After release and a new sample, full 34-cycle sequence repeats.
- CNT_W = 4, 17 back-to-back samples: sample_cnt wraps 15 → 0 → 1. Each accept is spaced ≥ 2·NTAPS+3 cycles.

Source files
------------

// File: rtl/lms_seq_pkg.sv
// Shared definitions for the LMS tap sequencer.
// Holds the controller state encoding, the default tap count and the
// tap-index width derivation used by the top and the tap counter.
package lms_seq_pkg;

    localparam int NTAPS_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SHIFT = 3'd1,
        ST_MAC   = 3'd2,
        ST_ERR   = 3'd3,
        ST_UPD   = 3'd4,
        ST_OUT   = 3'd5
    } state_t;

    // Index width for a given tap count; never narrower than one bit.
    function automatic int idx_width(input int ntaps);
        if (ntaps <= 2) begin
            return 1;
        end else begin
            return $clog2(ntaps);
        end
    endfunction

endpackage

// File: rtl/lms_tap_counter.sv
// Tap index counter shared by the MAC and weight-update passes.
// Ports:
//   clk, rstn  : clock, asynchronous active-low reset
//   i_clr      : synchronous clear to 0 (wins over i_en)
//   i_en       : advance the index; wraps to 0 after NTAPS-1
//   o_idx      : current tap index (registered)
//   o_tc       : terminal count, high while o_idx == NTAPS-1
module lms_tap_counter
    import lms_seq_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int IDX_W = idx_width(NTAPS)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_clr,
    input  logic             i_en,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_tc
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NTAPS - 1);

    logic [IDX_W-1:0] r_idx;

    // Index register: clear has priority, wrap at the last tap so the
    // index is already 0 when the next pass (or state) begins.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx <= '0;
        end else if (i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            if (r_idx == LAST_IDX) begin
                r_idx <= '0;
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_idx <= r_idx;
        end
    end

    assign o_idx = r_idx;
    assign o_tc  = (r_idx == LAST_IDX);

endmodule

// File: rtl/lms_tap_sequencer.sv
// Control FSM sequencing one LMS iteration per input sample:
// shift delay line, MAC pass over all taps, error strobe, optional
// weight-update pass, then output handshake. Generates strobes only.
// Ports:
//   clk, rstn                : clock, asynchronous active-low reset
//   i_enable                 : run enable; low aborts any iteration
//   i_freeze                 : skip weight update (sampled in ERR)
//   i_in_valid / o_in_ready  : sample input handshake (ready only in IDLE)
//   o_out_valid / i_out_ready: result handshake
//   o_shift_en, o_mac_clr    : delay-line shift / accumulator clear pulses
//   o_mac_en, o_err_en       : accumulate enable / error latch pulse
//   o_upd_en, o_w_we         : weight update and RAM write enable
//   o_tap_idx                : tap index during MAC/UPD, else 0
//   o_busy                   : high in every state except IDLE
//   o_sample_cnt             : completed iterations, wrapping
module lms_tap_sequencer
    import lms_seq_pkg::*;
#(
    parameter int NTAPS = NTAPS_DEF,
    parameter int IDX_W = idx_width(NTAPS),
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_enable,
    input  logic             i_freeze,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic             o_shift_en,
    output logic             o_mac_clr,
    output logic             o_mac_en,
    output logic             o_err_en,
    output logic             o_upd_en,
    output logic             o_w_we,
    output logic [IDX_W-1:0] o_tap_idx,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_sample_cnt
);

    state_t           r_state;
    state_t           w_next;
    logic             w_abort;
    logic             w_cnt_inc;
    logic             r_abort_clr;
    logic [CNT_W-1:0] r_sample_cnt;
    logic             w_tc;
    logic             w_idx_en;
    logic             w_idx_clr;

    // Counter runs only in the two tap passes; any other state or an
    // abort holds it at 0 so tap_idx reads 0 outside MAC/UPD.
    assign w_idx_en  = (r_state == ST_MAC) || (r_state == ST_UPD);
    assign w_idx_clr = !w_idx_en || !i_enable;

    lms_tap_counter #(
        .NTAPS (NTAPS),
        .IDX_W (IDX_W)
    ) u_tap_counter (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (w_idx_clr),
        .i_en  (w_idx_en),
        .o_idx (o_tap_idx),
        .o_tc  (w_tc)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; an enable drop outranks every transition,
    // including an output handshake in the same cycle.
    always_comb begin
        w_next    = r_state;
        w_abort   = 1'b0;
        w_cnt_inc = 1'b0;
        if ((r_state != ST_IDLE) && !i_enable) begin
            w_next  = ST_IDLE;
            w_abort = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable && i_in_valid) w_next = ST_SHIFT;
                    else                        w_next = ST_IDLE;
                end
                ST_SHIFT: w_next = ST_MAC;
                ST_MAC: begin
                    if (w_tc) w_next = ST_ERR;
                    else      w_next = ST_MAC;
                end
                ST_ERR: begin
                    if (i_freeze) w_next = ST_OUT;
                    else          w_next = ST_UPD;
                end
                ST_UPD: begin
                    if (w_tc) w_next = ST_OUT;
                    else      w_next = ST_UPD;
                end
                ST_OUT: begin
                    if (i_out_ready) begin
                        w_next    = ST_IDLE;
                        w_cnt_inc = 1'b1;
                    end else begin
                        w_next = ST_OUT;
                    end
                end
                default: w_next = ST_IDLE;
            endcase
        end
    end

    // Completed-iteration counter and post-abort accumulator clear flag.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_sample_cnt <= '0;
            r_abort_clr  <= 1'b0;
        end else begin
            r_abort_clr <= w_abort;
            if (w_cnt_inc) begin
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            end else begin
                r_sample_cnt <= r_sample_cnt;
            end
        end
    end

    // Moore strobes decoded from the state register; the abort clear
    // is the only strobe that appears in IDLE.
    assign o_in_ready   = (r_state == ST_IDLE) && i_enable;
    assign o_shift_en   = (r_state == ST_SHIFT);
    assign o_mac_clr    = (r_state == ST_SHIFT) || r_abort_clr;
    assign o_mac_en     = (r_state == ST_MAC);
    assign o_err_en     = (r_state == ST_ERR);
    assign o_upd_en     = (r_state == ST_UPD);
    assign o_w_we       = (r_state == ST_UPD);
    assign o_out_valid  = (r_state == ST_OUT);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_sample_cnt = r_sample_cnt;

endmodule
